// File: rtl/keccak_pkg.sv
// Shared Keccak definitions for the rho rotate engine: lane geometry, the
// standard rho offset table (indexed by lane 5*y+x), the lane index helper and
// the FSM state encoding.
package keccak_pkg;

  localparam int NUM_LANES = 25;
  localparam int ROW       = 5;

  // FSM state encoding
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_EMIT = 2'd2;

  // Standard Keccak rho offsets, ordered by lane index 5*y+x
  localparam logic [5:0] RHO_OFFSETS [NUM_LANES] = '{
    6'd0,  6'd1,  6'd62, 6'd28, 6'd27,   // y = 0
    6'd36, 6'd44, 6'd6,  6'd55, 6'd20,   // y = 1
    6'd3,  6'd10, 6'd43, 6'd25, 6'd39,   // y = 2
    6'd41, 6'd45, 6'd15, 6'd21, 6'd8,    // y = 3
    6'd18, 6'd2,  6'd61, 6'd56, 6'd14    // y = 4
  };

  // Position of lane (x,y) inside a 25-bit slice
  function automatic logic [4:0] lane_idx(input logic [2:0] x, input logic [2:0] y);
    return 5'd5 * {2'b00, y} + {2'b00, x};
  endfunction

endpackage

// File: rtl/rho_rotate_engine_if.sv
// Slice streaming bus of the rho rotate engine: an input slice stream and an
// output slice stream, both valid/ready. The engine uses the slave modport,
// the surrounding pipeline (or a testbench) the master modport.
interface rho_rotate_engine_if;

  logic        in_valid;
  logic        in_ready;
  logic [24:0] in_slice;
  logic        out_valid;
  logic        out_ready;
  logic [24:0] out_slice;

  modport slave (
    input  in_valid, in_slice, out_ready,
    output in_ready, out_valid, out_slice
  );

  modport master (
    output in_valid, in_slice, out_ready,
    input  in_ready, out_valid, out_slice
  );

endinterface

// File: rtl/rho_offset_rom.sv
// Combinational rho offset lookup: lane index -> rho offset reduced mod LANE_W.
// LANE_W is a power of two, so the reduction is a plain truncation.
module rho_offset_rom
  import keccak_pkg::*;
#(
  parameter  int LANE_W = 64,
  localparam int CNT_W  = $clog2(LANE_W)
) (
  input  logic [4:0]       lane,
  output logic [CNT_W-1:0] offset
);

  logic [5:0] full_s;

  // Table lookup with out-of-range lane indices mapped to offset 0
  always_comb begin
    full_s = 6'd0;
    if (lane < 5'd25) begin
      full_s = RHO_OFFSETS[lane];
    end else begin
      full_s = 6'd0;
    end
    offset = full_s[CNT_W-1:0];
  end

endmodule

// File: rtl/rho_rotate_engine.sv
// Slice-serial Keccak rho step. Loads one 5x5xLANE_W state as LANE_W slices,
// then streams out rotated slices where lane (x,y) bit z comes from input bit
// (z - r[x][y]) mod LANE_W. Index arithmetic is CNT_W bits wide, so the
// modulo is natural wrap-around.
// Optional feature macro: RHO_INVERSE_EN -- when defined, inv is captured at
// start and inv=1 selects (z + r) mod LANE_W, which undoes rho.
module rho_rotate_engine
  import keccak_pkg::*;
#(
  parameter  int LANE_W = 64,
  localparam int CNT_W  = $clog2(LANE_W)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             inv,
  rho_rotate_engine_if.slave bus,
  output logic [CNT_W-1:0] cnt_value,
  output logic             busy,
  output logic             done
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(LANE_W - 1);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  logic [1:0]        state_r;
  logic [CNT_W-1:0]  cnt_r;
  logic [LANE_W-1:0] lane_buf_r [NUM_LANES];
  logic              out_valid_r;
  logic [24:0]       out_slice_r;
  logic              done_r;
  logic              inv_sel_s;

  logic [CNT_W-1:0]  off_s [NUM_LANES];
  logic [CNT_W-1:0]  src_s [NUM_LANES];
  logic [CNT_W-1:0]  z_sel_s;
  logic [24:0]       next_slice_s;
  logic              in_xfer_s;

`ifdef RHO_INVERSE_EN
  logic inv_r;

  // Direction is captured at start and held for the whole transfer
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inv_r <= 1'b0;
    end else if (state_r == ST_IDLE && start) begin
      inv_r <= inv;
    end
  end

  assign inv_sel_s = inv_r;
`else
  logic unused_inv_s;
  assign unused_inv_s = inv;
  assign inv_sel_s    = 1'b0;
`endif

  // One offset ROM per lane, addressed by its constant lane index
  for (genvar gy = 0; gy < ROW; gy++) begin : g_row
    for (genvar gx = 0; gx < ROW; gx++) begin : g_col
      localparam logic [4:0] LANE = lane_idx(3'(gx), 3'(gy));
      rho_offset_rom #(.LANE_W(LANE_W)) u_rom (
        .lane   (LANE),
        .offset (off_s[LANE])
      );
    end
  end

  assign in_xfer_s = (state_r == ST_LOAD) && bus.in_valid;

  // Slice index to fetch: the current one before the first slice is shown,
  // afterwards the next one so a slice can leave every cycle
  always_comb begin
    z_sel_s = cnt_r;
    if (out_valid_r) begin
      z_sel_s = cnt_r + ONE;
    end else begin
      z_sel_s = cnt_r;
    end
  end

  // Gather the rotated slice: each lane reads its own bit column
  always_comb begin
    next_slice_s = 25'd0;
    for (int l = 0; l < NUM_LANES; l++) begin
      if (inv_sel_s) begin
        src_s[l] = z_sel_s + off_s[l];
      end else begin
        src_s[l] = z_sel_s - off_s[l];
      end
      next_slice_s[l] = lane_buf_r[l][src_s[l]];
    end
  end

  // State buffer: each accepted input slice fills one bit column
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int l = 0; l < NUM_LANES; l++) begin
        lane_buf_r[l] <= '0;
      end
    end else if (in_xfer_s) begin
      for (int l = 0; l < NUM_LANES; l++) begin
        lane_buf_r[l][cnt_r] <= bus.in_slice[l];
      end
    end
  end

  // Transfer FSM, slice counter and registered output stream
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= ST_IDLE;
      cnt_r       <= '0;
      out_valid_r <= 1'b0;
      out_slice_r <= 25'd0;
      done_r      <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            state_r <= ST_LOAD;
            cnt_r   <= '0;
          end
        end
        ST_LOAD: begin
          if (in_xfer_s) begin
            cnt_r <= cnt_r + ONE;
            if (cnt_r == LAST) begin
              state_r <= ST_EMIT;
            end
          end
        end
        ST_EMIT: begin
          if (!out_valid_r) begin
            out_valid_r <= 1'b1;
            out_slice_r <= next_slice_s;
          end else if (bus.out_ready) begin
            if (cnt_r == LAST) begin
              state_r     <= ST_IDLE;
              cnt_r       <= '0;
              out_valid_r <= 1'b0;
              out_slice_r <= 25'd0;
              done_r      <= 1'b1;
            end else begin
              cnt_r       <= cnt_r + ONE;
              out_slice_r <= next_slice_s;
            end
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          cnt_r       <= '0;
          out_valid_r <= 1'b0;
          out_slice_r <= 25'd0;
        end
      endcase
    end
  end

  assign bus.in_ready  = (state_r == ST_LOAD);
  assign bus.out_valid = out_valid_r;
  assign bus.out_slice = out_slice_r;
  assign cnt_value     = cnt_r;
  assign busy          = (state_r != ST_IDLE);
  assign done          = done_r;

endmodule

// File: tb/tb_rho_rotate_engine.sv
// Randomised self-checking bench for rho_rotate_engine. Two instances
// (LANE_W=64 and LANE_W=8) share the stream inputs; start is steered to one
// instance at a time. Expected output slices come from a lane/bit array model
// using the Keccak rho table written as r[x][y].
module tb_rho_rotate_engine;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        inv;
  logic        in_valid;
  logic [24:0] in_slice;
  logic        out_ready;
  int          sel;

  rho_rotate_engine_if bus_a ();
  rho_rotate_engine_if bus_b ();

  logic [5:0] cnt_a;
  logic [2:0] cnt_b;
  logic       busy_a, busy_b, done_a, done_b;

  assign bus_a.in_valid  = in_valid;
  assign bus_a.in_slice  = in_slice;
  assign bus_a.out_ready = out_ready;
  assign bus_b.in_valid  = in_valid;
  assign bus_b.in_slice  = in_slice;
  assign bus_b.out_ready = out_ready;

  rho_rotate_engine #(.LANE_W(64)) dut_a (
    .clk       (clk),
    .rst       (rst),
    .start     (start && (sel == 0)),
    .inv       (inv),
    .bus       (bus_a),
    .cnt_value (cnt_a),
    .busy      (busy_a),
    .done      (done_a)
  );

  rho_rotate_engine #(.LANE_W(8)) dut_b (
    .clk       (clk),
    .rst       (rst),
    .start     (start && (sel == 1)),
    .inv       (inv),
    .bus       (bus_b),
    .cnt_value (cnt_b),
    .busy      (busy_b),
    .done      (done_b)
  );

  always #5 clk = ~clk;

  // Outputs of the selected instance
  logic        ov, ir, bz, dn;
  logic [24:0] os;
  int          cv;
  always_comb begin
    ov = (sel == 1) ? bus_b.out_valid : bus_a.out_valid;
    ir = (sel == 1) ? bus_b.in_ready  : bus_a.in_ready;
    os = (sel == 1) ? bus_b.out_slice : bus_a.out_slice;
    bz = (sel == 1) ? busy_b : busy_a;
    dn = (sel == 1) ? done_b : done_a;
    cv = (sel == 1) ? int'(cnt_b) : int'(cnt_a);
  end

  // ---------------- reference model ----------------
  int rho_r [5][5] = '{'{0, 36, 3, 41, 18}, '{1, 44, 10, 45, 2}, '{62, 6, 43, 15, 61},
                       '{28, 55, 25, 21, 56}, '{27, 20, 39, 8, 14}};
  bit st [25][64];
  int lw = 64;
  bit eff_inv = 1'b0;

  int n_vec = 0;
  int n_err = 0;
  int exp_z = 0;
  int n_rcv = 0;
  int n_done = 0;
  logic [24:0] got [64];

  function automatic logic [24:0] exp_slice(input int z);
    logic [24:0] s;
    int r, src;
    s = '0;
    for (int l = 0; l < 25; l++) begin
      r   = rho_r[l % 5][l / 5] % lw;
      src = eff_inv ? (z + r) % lw : (z - r + lw) % lw;
      s[l] = st[l][src];
    end
    return s;
  endfunction

  function automatic logic [24:0] in_of(input int z);
    logic [24:0] s;
    s = '0;
    for (int l = 0; l < 25; l++) s[l] = st[l][z];
    return s;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, expv, $time);
    end
  endtask

  // Compare process: every shown output slice against the model
  always @(negedge clk) begin
    if (!bz) exp_z = 0;
    if (rst && ov) begin
      chk("out_slice", 32'(os), 32'(exp_slice(exp_z)));
      chk("cnt_value", 32'(cv), 32'(exp_z));
      if (out_ready) begin
        got[exp_z % 64] = os;
        exp_z++;
        n_rcv++;
      end
    end
    if (dn) n_done++;
  end

  // ---------------- stimulus helpers ----------------
  task automatic clear_state();
    for (int l = 0; l < 25; l++) for (int b = 0; b < 64; b++) st[l][b] = 1'b0;
  endtask

  task automatic random_state();
    for (int l = 0; l < 25; l++) for (int b = 0; b < 64; b++) st[l][b] = 1'($urandom);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // stall < 0: out_ready low for exactly three cycles mid-stream
  task automatic run_xfer(input int s, input bit iv, input int gap, input int stall, input bit poke);
    int lwv, r0, d0, cyc;
    lwv = (s == 1) ? 8 : 64;
    sel = s;
    lw  = lwv;
`ifdef RHO_INVERSE_EN
    eff_inv = iv;
`else
    eff_inv = 1'b0;
`endif
    start = 1'b1;
    inv   = iv;
    tick();
    start = 1'b0;
    for (int z = 0; z < lwv; z++) begin
      while ($urandom_range(99) < gap) begin
        in_valid = 1'b0;
        in_slice = 25'($urandom);
        tick();
      end
      in_valid = 1'b1;
      in_slice = in_of(z);
      if (poke && z == 3) begin
        start = 1'b1;
        inv   = ~iv;
      end
      @(negedge clk);
      chk("in_ready", 32'(ir), 32'd1);
      tick();
      start = 1'b0;
      inv   = iv;
    end
    in_valid = 1'b0;
    in_slice = 25'($urandom);
    r0  = n_rcv;
    d0  = n_done;
    cyc = 0;
    while ((n_rcv - r0) < lwv && cyc < 3000) begin
      if (stall < 0) out_ready = !(cyc >= 10 && cyc < 13);
      else           out_ready = ($urandom_range(99) >= stall);
      tick();
      cyc++;
    end
    out_ready = 1'b0;
    chk("slices_out", 32'(n_rcv - r0), 32'(lwv));
    tick();
    tick();
    chk("done_once", 32'(n_done - d0), 32'd1);
    chk("idle_after", 32'(bz), 32'd0);
  endtask

  task automatic check_reset_outputs(input int s);
    sel = s;
    @(negedge clk);
    chk("rst_out_valid", 32'(ov), 32'd0);
    chk("rst_in_ready", 32'(ir), 32'd0);
    chk("rst_out_slice", 32'(os), 32'd0);
    chk("rst_cnt", 32'(cv), 32'd0);
    chk("rst_busy", 32'(bz), 32'd0);
    chk("rst_done", 32'(dn), 32'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int d0;
    rst = 1'b0; start = 1'b0; inv = 1'b0; in_valid = 1'b0;
    in_slice = 25'd0; out_ready = 1'b0; sel = 0;
    clear_state();
    tick(); tick();
    check_reset_outputs(0);
    check_reset_outputs(1);
    tick();
    rst = 1'b1;
    tick();

    // Lane (1,0) bit 0 -> slice 1 bit 1
    clear_state();
    st[1][0] = 1'b1;
    run_xfer(0, 1'b0, 0, 0, 1'b0);
    chk("t1_slice1", 32'(got[1]), 32'h2);
    chk("t1_slice0", 32'(got[0]), 32'h0);
    chk("t1_slice2", 32'(got[2]), 32'h0);

    // Inverse on the rotated pattern (lane 1 bit 1)
    clear_state();
    st[1][1] = 1'b1;
    run_xfer(0, 1'b1, 10, 20, 1'b1);
`ifdef RHO_INVERSE_EN
    chk("t6_restored", 32'(got[0]), 32'h2);
    chk("t6_slice1", 32'(got[1]), 32'h0);
`else
    chk("t6_fwd_only", 32'(got[2]), 32'h2);
    chk("t6_slice0", 32'(got[0]), 32'h0);
`endif

    // Lane (2,0) bit 5 -> slice 3 bit 2; lane (0,0) bit 5 stays
    clear_state();
    st[2][5] = 1'b1;
    st[0][5] = 1'b1;
    run_xfer(0, 1'b0, 0, 30, 1'b0);
    chk("t2_slice3", 32'(got[3]), 32'h4);
    chk("t2_slice5", 32'(got[5]), 32'h1);

    // LANE_W=8: lane (2,0) bit 0 -> slice 6 bit 2
    clear_state();
    st[2][0] = 1'b1;
    run_xfer(1, 1'b0, 0, 0, 1'b0);
    chk("t3_slice6", 32'(got[6]), 32'h4);
    chk("t3_slice0", 32'(got[0]), 32'h0);

    // Three-cycle out_ready stall mid-stream
    random_state();
    run_xfer(0, 1'b0, 0, -1, 1'b0);
    random_state();
    run_xfer(1, 1'b0, 0, -1, 1'b0);

    // Reset during load at slice 20
    random_state();
    sel = 0;
    d0 = n_done;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int z = 0; z < 20; z++) begin
      in_valid = 1'b1;
      in_slice = in_of(z);
      tick();
    end
    rst = 1'b0;
    in_valid = 1'b0;
    check_reset_outputs(0);
    tick();
    rst = 1'b1;
    tick(); tick();
    chk("t5_no_done", 32'(n_done - d0), 32'd0);
    random_state();
    run_xfer(0, 1'b0, 20, 20, 1'b0);

    // Random states, gaps, stalls, inversion and stray start pulses
    for (int k = 0; k < 6; k++) begin
      random_state();
      run_xfer(k % 2, 1'($urandom), $urandom_range(40), $urandom_range(50), 1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
